// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master issues requests and operands; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a borrow
// flip-flop compute a - b LSB first, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             borrow;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             overflow_r;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             a_msb;
  logic             b_msb;

  logic             d_bit;
  logic             w_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] shifted;

  function automatic logic fs_diff(input logic x, input logic y, input logic w);
    return x ^ y ^ w;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic w);
    return (~x & y) | (~(x ^ y) & w);
  endfunction

  function automatic logic sub_ovf(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  always_comb begin
    d_bit   = fs_diff(sa[0], sb[0], borrow);
    w_next  = fs_borrow(sa[0], sb[0], borrow);
    accept  = bus.start && ((state == IDLE) || (state == DONE));
    last    = (state == SHIFT) && (count == CNT_W'(WIDTH - 1));
    shifted = {d_bit, res};
  end

  // Control: state, counter, borrow and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      borrow       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (accept) begin
            state  <= SHIFT;
            busy_r <= 1'b1;
            count  <= '0;
            borrow <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          borrow <= w_next;
          count  <= count + CNT_W'(1);
          if (last) begin
            state        <= DONE;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            diff_r       <= shifted;
            borrow_out_r <= w_next;
            overflow_r   <= sub_ovf(a_msb, b_msb, d_bit);
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand shift registers and the partial result, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa    <= bus.a;
      sb    <= bus.b;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= shifted[WIDTH-1:1];
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expectations are queued at each start
// edge and popped whenever done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   lat;
  logic [W-1:0] held_diff;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff = a - b;
    e.bo   = (a < b);
    e.ov   = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", bus.diff, mon_e.diff);
        check("borrow_out", bus.borrow_out, mon_e.bo);
        check("overflow", bus.overflow, mon_e.ov);
      end
    end
  end

  // Drive one start pulse at a negedge; operands are scrambled right after the edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Wait for done at negedges; n = number of negedges up to and including done.
  task automatic wait_done(input int exp_lat, output int n);
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
    end while (bus.done !== 1'b1 && n < 40);
    if (bus.done !== 1'b1) begin
      check("done_timeout", 0, 1);
    end else begin
      check("busy_at_done", bus.busy, 0);
      if (exp_lat > 0) begin
        check("latency", n, exp_lat);
        check("busy_cycles", busy_cnt, W);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_borrow", bus.borrow_out, 0);
    check("rst_ovf", bus.overflow, 0);

    start_op(8'h00, 8'h00);
    wait_done(W + 1, lat);

    start_op(8'd100, 8'd37);
    wait_done(W + 1, lat);
    held_diff = bus.diff;
    repeat (5) @(negedge clk);
    check("hold_diff", bus.diff, held_diff);
    check("hold_diff_value", bus.diff, 8'd63);
    check("idle_busy", bus.busy, 0);

    start_op(8'h00, 8'h01);
    wait_done(W + 1, lat);
    start_op(8'h80, 8'h01);
    wait_done(W + 1, lat);
    start_op(8'h7F, 8'h80);
    wait_done(W + 1, lat);
    start_op(8'hA5, 8'hA5);
    wait_done(W + 1, lat);

    // Start while busy is ignored.
    start_op(8'd5, 8'd3);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 8'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, lat);
    check("ignored_start_lat", lat, W + 1 - 3);
    repeat (3) @(negedge clk);
    start_op(8'd9, 8'd9);
    wait_done(W + 1, lat);

    // Reset mid-operation aborts without a done pulse.
    start_op(8'd50, 8'd20);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_diff", bus.diff, 0);
    check("abort_borrow", bus.borrow_out, 0);
    check("abort_ovf", bus.overflow, 0);
    repeat (12) @(negedge clk);
    check("abort_idle_busy", bus.busy, 0);
    start_op(8'd50, 8'd20);
    wait_done(W + 1, lat);

    // Start held high: a new operation each time DONE is reached.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd17;
    sb_q.push_back(model(8'd200, 8'd17));
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      wait_done(W + 1, lat);
      if (k < 5) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        sb_q.push_back(model(bus.a, bus.b));
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    // Random operand pairs.
    for (int i = 0; i < 1000; i++) begin
      start_op(W'($urandom), W'($urandom));
      wait_done(0, lat);
    end

    repeat (12) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
